// File: rtl/seg_pkg.sv
// Shared digit record, display constants and hex-to-segment decode for the scan controller.
// Pure combinational helpers with no latency and no flow control.
package seg_pkg;

    localparam int         NDIG      = 4;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] DIG_OFF   = 4'hF;

    typedef struct packed {
        logic       dp;
        logic [3:0] code;
    } digit_t;

    // Active-low {DP,G..A}; DP is forced off here and patched in by seg_encode.
    function automatic logic [7:0] seg_hex(input logic [3:0] code);
        logic [7:0] s;
        case (code)
            4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
            4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
            4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
            4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
        endcase
        return s;
    endfunction

    function automatic logic [7:0] seg_encode(input digit_t d);
        logic [7:0] s;
        s = seg_hex(d.code);
        return {~d.dp, s[6:0]};
    endfunction

endpackage

// File: rtl/seg_rr_arb2.sv
// Two-way round-robin arbiter for the digit write ports; readies are combinational from valids.
// Zero latency; a loser simply sees ready low and holds its request until granted.
module seg_rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic a_valid_i,
    input  logic b_valid_i,
    output logic a_ready_o,
    output logic b_ready_o
);

    logic last_b_q;

    // On contention the side that did not win last goes next.
    always_comb begin
        a_ready_o = !rst && a_valid_i && (!b_valid_i ||  last_b_q);
        b_ready_o = !rst && b_valid_i && (!a_valid_i || !last_b_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_b_q <= 1'b1;
        end else if (a_ready_o) begin
            last_b_q <= 1'b0;
        end else if (b_ready_o) begin
            last_b_q <= 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit multiplexed 7-segment controller: shadow/live digit buffers, dwell scan, PWM, dead time.
// Pin outputs are registered one clock behind scan state; writers are throttled by the arbiter only.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DWELL    = 150000,
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [1:0]          a_addr,
    input  logic [3:0]          a_code,
    input  logic                a_dp,
    input  logic                b_valid,
    output logic                b_ready,
    input  logic [1:0]          b_addr,
    input  logic [3:0]          b_code,
    input  logic                b_dp,
    input  logic [PWM_BITS-1:0] brightness,
    input  logic [3:0]          blank_mask,
    output logic [3:0]          digits,
    output logic [7:0]          segments,
    output logic                frame_tick
);

    localparam int            DW         = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

    logic [DW-1:0]       dwell_cnt_q;
    logic [1:0]          idx_q;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [3:0]          digits_q;
    logic [7:0]          segments_q;
    digit_t              shadow_q [NDIG];
    digit_t              shadow_d [NDIG];
    digit_t              live_q   [NDIG];
    digit_t              wr_dat;
    logic [1:0]          wr_addr;
    logic                wr_en;
    logic                deadtime;
    logic                lit;

    seg_rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .a_valid_i (a_valid),
        .b_valid_i (b_valid),
        .a_ready_o (a_ready),
        .b_ready_o (b_ready)
    );

    assign wr_en   = a_ready | b_ready;
    assign wr_addr = a_ready ? a_addr : b_addr;
    assign wr_dat  = a_ready ? digit_t'{dp: a_dp, code: a_code} : digit_t'{dp: b_dp, code: b_code};

    // Forwarded view so a write landing on the commit edge is not lost from this frame.
    always_comb begin
        shadow_d = shadow_q;
        if (wr_en) begin
            shadow_d[wr_addr] = wr_dat;
        end
    end

    assign frame_tick = (dwell_cnt_q == '0) && (idx_q == 2'd3);
    assign deadtime   = (dwell_cnt_q == DWELL_LAST);
    assign lit        = !deadtime && !blank_mask[idx_q] && (pwm_cnt_q < brightness);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_cnt_q <= DWELL_LAST;
            idx_q       <= 2'd0;
            pwm_cnt_q   <= '0;
            digits_q    <= DIG_OFF;
            segments_q  <= SEG_BLANK;
            for (int i = 0; i < NDIG; i++) begin
                shadow_q[i] <= '0;
                live_q[i]   <= '0;
            end
        end else begin
            if (dwell_cnt_q == '0) begin
                dwell_cnt_q <= DWELL_LAST;
                idx_q       <= idx_q + 2'd1;
            end else begin
                dwell_cnt_q <= dwell_cnt_q - 1'b1;
            end
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            shadow_q  <= shadow_d;
            if (frame_tick) begin
                live_q <= shadow_d;
            end
            digits_q   <= lit ? ~(4'b0001 << idx_q) : DIG_OFF;
            segments_q <= seg_encode(live_q[idx_q]);
        end
    end

    assign digits   = digits_q;
    assign segments = segments_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: a cycle-count based display model checked every cycle,
// plus hand-computed literals for scan order, commit timing, arbitration, PWM, blanking and reset.
module tb_seg_scan_ctrl;

    localparam int DWELL = 4;
    localparam int FRAME = 4 * DWELL;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       a_valid = 1'b0, b_valid = 1'b0;
    logic       a_ready, b_ready;
    logic [1:0] a_addr = 2'd0, b_addr = 2'd0;
    logic [3:0] a_code = 4'd0, b_code = 4'd0;
    logic       a_dp = 1'b0, b_dp = 1'b0;
    logic [3:0] brightness = 4'hF;
    logic [3:0] blank_mask = 4'h0;
    logic [3:0] digits;
    logic [7:0] segments;
    logic       frame_tick;

    logic       lo1 = 1'b0;
    logic [1:0] lo2 = 2'd0;
    logic [3:0] lo4 = 4'd0;
    logic [3:0] br40 = 4'd8;
    logic       a_ready40, b_ready40, frame_tick40;
    logic [3:0] digits40;
    logic [7:0] segments40;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.DWELL(DWELL), .PWM_BITS(4)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_code(a_code), .a_dp(a_dp),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_code(b_code), .b_dp(b_dp),
        .brightness(brightness), .blank_mask(blank_mask),
        .digits(digits), .segments(segments), .frame_tick(frame_tick)
    );

    seg_scan_ctrl #(.DWELL(40), .PWM_BITS(4)) dut40 (
        .clk(clk), .rst(rst),
        .a_valid(lo1), .a_ready(a_ready40), .a_addr(lo2), .a_code(lo4), .a_dp(lo1),
        .b_valid(lo1), .b_ready(b_ready40), .b_addr(lo2), .b_code(lo4), .b_dp(lo1),
        .brightness(br40), .blank_mask(lo4),
        .digits(digits40), .segments(segments40), .frame_tick(frame_tick40)
    );

    int errors = 0;
    int checks = 0;

    // Model: everything derives from k = clock edges since reset release.
    int         k;
    logic [4:0] m_shadow [4];
    logic [4:0] m_live   [4];
    bit         m_last_b;
    logic [3:0] e_dig;
    logic [7:0] e_seg;

    logic [7:0] seen [4];
    logic [1:0] g_last;
    int lit_cnt, blk_cnt, tick_cnt, last_tick_k, tick_gap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (k=%0d, t=%0t)", name, act, exp, k, $time);
        end
    endtask

    function automatic logic [7:0] hexseg(input logic [3:0] c);
        case (c)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    task automatic model_reset();
        k = 0;
        for (int i = 0; i < 4; i++) begin
            m_shadow[i] = 5'd0;
            m_live[i]   = 5'd0;
        end
        m_last_b = 1'b1;
        e_dig = 4'hF;
        e_seg = 8'hFF;
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 4; i++) seen[i] = 8'h00;
        lit_cnt = 0; blk_cnt = 0; tick_cnt = 0; last_tick_k = -1; tick_gap = 0;
    endtask

    // Called just after a negedge with inputs already applied; returns after the next negedge.
    task automatic step();
        bit         ea, eb, tick;
        int         idx, pos, pwm;
        logic [3:0] nd;
        logic [7:0] h, ns;
        #1;
        ea = a_valid && (!b_valid || m_last_b);
        eb = b_valid && (!a_valid || !m_last_b);
        check("a_ready", a_ready, ea);
        check("b_ready", b_ready, eb);
        g_last = {a_ready, b_ready};
        idx  = (k % FRAME) / DWELL;
        pos  = k % DWELL;
        pwm  = k % 16;
        tick = (pos == DWELL - 1) && (idx == 3);
        nd = (pos != 0 && !blank_mask[idx] && pwm < brightness) ? ~(4'b0001 << idx) : 4'hF;
        h  = hexseg(m_live[idx][3:0]);
        ns = {~m_live[idx][4], h[6:0]};
        @(posedge clk);
        if (ea) m_shadow[a_addr] = {a_dp, a_code};
        else if (eb) m_shadow[b_addr] = {b_dp, b_code};
        if (ea) m_last_b = 1'b0;
        else if (eb) m_last_b = 1'b1;
        if (tick) for (int i = 0; i < 4; i++) m_live[i] = m_shadow[i];
        k++;
        e_dig = nd;
        e_seg = ns;
        @(negedge clk);
        check("digits", digits, e_dig);
        check("segments", segments, e_seg);
        check("frame_tick", frame_tick,
              (k % DWELL == DWELL - 1) && ((k % FRAME) / DWELL == 3));
        for (int i = 0; i < 4; i++)
            if (digits == ~(4'b0001 << i)) seen[i] = segments;
        if (digits != 4'hF) lit_cnt++;
        if (digits == 4'hB) blk_cnt++;
        if (frame_tick) begin
            if (last_tick_k >= 0) tick_gap = k - last_tick_k;
            last_tick_k = k;
            tick_cnt++;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    logic [3:0] t1_tab [16];
    int         cnt40;
    logic [1:0] grant_exp [4];

    initial begin
        t1_tab = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                   4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'hF};
        grant_exp = '{2'b10, 2'b01, 2'b10, 2'b01};
        model_reset();
        clear_stats();

        // Reset with no clock edge yet; requests present must not be granted.
        a_valid = 1'b1; b_valid = 1'b1;
        #1 rst = 1'b1;
        #1;
        check("rst_digits", digits, 4'hF);
        check("rst_segments", segments, 8'hFF);
        check("rst_a_ready", a_ready, 1'b0);
        check("rst_b_ready", b_ready, 1'b0);
        check("rst_frame_tick", frame_tick, 1'b0);
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Scan order with dead time; PWM window on the long-dwell instance.
        cnt40 = 0;
        for (int i = 1; i <= 17; i++) begin
            step();
            if (i <= 16) check("t1_scan_digits", digits, t1_tab[i-1]);
            if (i <= 16) check("t1_segments", segments, 8'hC0);
            if (i == 15) check("t1_tick_at_15", frame_tick, 1'b1);
            if (i >= 2 && digits40 != 4'hF) cnt40++;
        end
        check("pwm8_of_16_dwell40", cnt40, 8);

        // Mid-frame write must not show until after the commit.
        a_valid = 1'b1; a_addr = 2'd1; a_code = 4'd3; a_dp = 1'b1;
        step();
        a_valid = 1'b0;
        clear_stats();
        while (k < 2 * FRAME) step();
        check("t2_digit1_before_commit", seen[1], 8'hC0);
        clear_stats();
        for (int i = 0; i < FRAME; i++) step();
        check("t2_digit1_after_commit", seen[1], 8'h30);

        // Contention: alternating grants, last transfer wins the address.
        @(negedge clk);
        pulse_reset();
        a_valid = 1'b1; a_addr = 2'd2; a_code = 4'd6; a_dp = 1'b0;
        b_valid = 1'b1; b_addr = 2'd2; b_code = 4'd9; b_dp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t3_grant", g_last, grant_exp[i]);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        while (k < FRAME) step();
        clear_stats();
        for (int i = 0; i < FRAME; i++) step();
        check("t3_digit2_committed", seen[2], 8'h90);

        // Brightness 0 keeps everything dark; 8 lights 6 of 16 once dead cycles are removed.
        brightness = 4'h0;
        clear_stats();
        for (int i = 0; i < FRAME; i++) step();
        check("t4_dark_count", lit_cnt, 0);
        brightness = 4'h8;
        clear_stats();
        for (int i = 0; i < FRAME; i++) step();
        check("t4_b8_lit_count", lit_cnt, 6);

        // Blanking digit 2.
        brightness = 4'hF;
        blank_mask = 4'b0100;
        clear_stats();
        for (int i = 0; i < 2 * FRAME; i++) step();
        check("t5_digit2_never", blk_cnt, 0);
        check("t5_lit_count", lit_cnt, 16);
        check("t5_tick_count", tick_cnt, 2);
        check("t5_tick_gap", tick_gap, 16);
        blank_mask = 4'h0;

        // Reset mid-dwell with a pending request.
        step();
        step();
        check("t6_pre_lit", digits, 4'hE);
        a_valid = 1'b1; a_addr = 2'd0; a_code = 4'd5;
        #1 rst = 1'b1;
        #1;
        check("t6_rst_digits", digits, 4'hF);
        check("t6_rst_segments", segments, 8'hFF);
        check("t6_rst_a_ready", a_ready, 1'b0);
        a_valid = 1'b0;
        rst = 1'b0;
        model_reset();
        clear_stats();
        for (int i = 0; i < FRAME; i++) step();
        for (int i = 0; i < 4; i++) check("t6_buffer_cleared", seen[i], 8'hC0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
